// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32 decode constants and the mul/div FSM state type.
package rv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX -> mul/div unit -> EX/MEM signal bundle.
// master: the pipeline side driving instruction fields; slave: the unit.
interface ex_muldiv_unit_if;

  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  func3_in;
  logic [6:0]  func7_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic [4:0]  rd_in;
  logic        kill_in;
  logic        stall_out;
  logic        result_valid_out;
  logic [31:0] result_out;
  logic [4:0]  rd_out;

  modport master (
    output valid_in, opcode_in, func3_in, func7_in, rs1_in, rs2_in, rd_in, kill_in,
    input  stall_out, result_valid_out, result_out, rd_out
  );

  modport slave (
    input  valid_in, opcode_in, func3_in, func7_in, rs1_in, rs2_in, rd_in, kill_in,
    output stall_out, result_valid_out, result_out, rd_out
  );

endinterface

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done is raised during the final step; quotient/remainder then show the
// post-step values so the caller can register the final result that edge.
module muldiv_div_core #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(STEPS + 1);

  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;

  logic [WIDTH:0]   rem_shift;
  logic             take;
  logic [WIDTH-1:0] rem_next, quo_next;

  // Shift remainder:quotient left, trial-subtract; remainder stays below the
  // divisor so the low WIDTH bits of the difference are exact when taken.
  assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign take      = rem_shift >= {1'b0, dvs_reg};
  assign rem_next  = take ? (rem_shift[WIDTH-1:0] - dvs_reg) : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_reg[WIDTH-2:0], take};

  assign busy      = busy_reg;
  assign done      = busy_reg && (cnt_reg == CW'(STEPS - 1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  // Load on start (restarts any abandoned run), otherwise step while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      dvs_reg  <= divisor;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit.
// Define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU; otherwise only the
// MUL* group is claimed and the divider is not built.
module ex_muldiv_unit
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input logic            clk,
  input logic            rst_n,
  ex_muldiv_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MUL  = MUL;
  localparam logic [1:0] ST_DIV  = DIV;
  localparam logic [1:0] ST_DONE = DONE;

  if (XLEN != 32 || DIV_STEPS != XLEN) begin : g_cfg_check
    $error("ex_muldiv_unit supports only XLEN=32 with DIV_STEPS=XLEN");
  end

  logic [1:0]      state_reg;
  logic [XLEN-1:0] rs1_reg, rs2_reg, result_reg;
  logic [1:0]      func3_reg;
  logic [4:0]      rd_reg, rd_out_reg;

  logic            is_m, claim;
  logic            a_signed, b_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0] mul_result;

`ifdef MULDIV_DIV_EN
  assign is_m = bus.valid_in && bus.opcode_in == OPC_OP && bus.func7_in == F7_MULDIV;
`else
  assign is_m = bus.valid_in && bus.opcode_in == OPC_OP && bus.func7_in == F7_MULDIV
                && !bus.func3_in[2];
`endif

  assign claim = (state_reg == ST_IDLE) && is_m && !bus.kill_in;

  assign bus.stall_out        = claim || state_reg == ST_MUL || state_reg == ST_DIV;
  assign bus.result_valid_out = (state_reg == ST_DONE) && !bus.kill_in;
  assign bus.result_out       = result_reg;
  assign bus.rd_out           = rd_out_reg;

  // MULHU treats A unsigned; MULHSU and MULHU treat B unsigned.
  assign a_signed   = func3_reg != 2'b11;
  assign b_signed   = !func3_reg[1];
  assign mul_a      = {{XLEN{a_signed & rs1_reg[XLEN-1]}}, rs1_reg};
  assign mul_b      = {{XLEN{b_signed & rs2_reg[XLEN-1]}}, rs2_reg};
  assign product    = mul_a * mul_b;
  assign mul_result = (func3_reg == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
  logic            div_signed, div_zero, div_ovf, div_special, div_start, div_done;
  logic [XLEN-1:0] dvd_mag, dvs_mag, div_quo, div_rem;
  logic [XLEN-1:0] special_result, quo_fix, rem_fix, div_result;
  logic            neg_q_reg, neg_r_reg;

  assign div_signed  = !bus.func3_in[0];
  assign div_zero    = bus.rs2_in == '0;
  assign div_ovf     = div_signed && bus.rs1_in == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_in == '1;
  assign div_special = div_zero || div_ovf;
  assign div_start   = claim && bus.func3_in[2] && !div_special;
  assign dvd_mag     = (div_signed && bus.rs1_in[XLEN-1]) ? -bus.rs1_in : bus.rs1_in;
  assign dvs_mag     = (div_signed && bus.rs2_in[XLEN-1]) ? -bus.rs2_in : bus.rs2_in;

  // Divide by zero: q=all ones, r=dividend. Overflow: q=dividend (MIN), r=0.
  assign special_result = div_zero ? (bus.func3_in[1] ? bus.rs1_in : '1)
                                   : (bus.func3_in[1] ? '0 : bus.rs1_in);

  assign quo_fix    = neg_q_reg ? -div_quo : div_quo;
  assign rem_fix    = neg_r_reg ? -div_rem : div_rem;
  assign div_result = func3_reg[1] ? rem_fix : quo_fix;

  muldiv_div_core #(
    .WIDTH (XLEN),
    .STEPS (DIV_STEPS)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .busy      (),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Result sign corrections captured at claim time for the divider path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (claim) begin
      neg_q_reg <= div_signed && (bus.rs1_in[XLEN-1] ^ bus.rs2_in[XLEN-1]);
      neg_r_reg <= div_signed && bus.rs1_in[XLEN-1];
    end
  end
`endif

  // Control FSM: capture on claim, compute, present one result in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      func3_reg  <= '0;
      rd_reg     <= '0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (claim) begin
            rs1_reg   <= bus.rs1_in;
            rs2_reg   <= bus.rs2_in;
            func3_reg <= bus.func3_in[1:0];
            rd_reg    <= bus.rd_in;
            if (!bus.func3_in[2]) begin
              state_reg <= ST_MUL;
`ifdef MULDIV_DIV_EN
            end else if (div_special) begin
              result_reg <= special_result;
              rd_out_reg <= bus.rd_in;
              state_reg  <= ST_DONE;
            end else begin
              state_reg <= ST_DIV;
`endif
            end
          end
        end
        ST_MUL: begin
          if (bus.kill_in) begin
            state_reg <= ST_IDLE;
          end else begin
            result_reg <= mul_result;
            rd_out_reg <= rd_reg;
            state_reg  <= ST_DONE;
          end
        end
        ST_DIV: begin
`ifdef MULDIV_DIV_EN
          if (bus.kill_in) begin
            state_reg <= ST_IDLE;
          end else if (div_done) begin
            result_reg <= div_result;
            rd_out_reg <= rd_reg;
            state_reg  <= ST_DONE;
          end
`else
          state_reg <= ST_IDLE;
`endif
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
